ps2_key_router: RTL and testbench

- Parametrised successor to the single-keyboard decode path. Consumes raw PS2 scan bytes (one-cycle strobe per byte), tracks E0 extended and F0 break prefixes, and maps keys through a parameter table onto NUM_CH player channels.
- Per channel it keeps a held-key bitmap and a make/break event FIFO with valid/ready handshake toward the processor's key registers.
- Supersedes the make-only, single-held-code indicator scheme. Sits between PS2_Interface and the processor.

---
 rtl/ps2_key_pkg.sv | 28 ++
 rtl/key_evt_fifo.sv | 47 ++++
 rtl/ps2_key_router.sv | 136 +++++++++++++
 tb/tb_ps2_key_router.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_pkg.sv
// Shared constants and types for the PS2 key router: scan prefixes, decoder states, default key map.
package ps2_key_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam int unsigned KEY_ENTRY_W = 9;

  typedef enum logic [1:0] {
    DEC_IDLE    = 2'd0,
    DEC_EXT     = 2'd1,
    DEC_BRK     = 2'd2,
    DEC_EXT_BRK = 2'd3
  } dec_state_e;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_entry_t;

  // Entry 15 (ch1 key 7) first down to entry 0 (ch0 key 0)
  localparam logic [2*8*KEY_ENTRY_W-1:0] DEFAULT_KEY_MAP = {
    9'h02E, 9'h025, 9'h02D, 9'h02C, 9'h023, 9'h01B, 9'h01C, 9'h01D,
    9'h04D, 9'h026, 9'h01E, 9'h016, 9'h174, 9'h172, 9'h16B, 9'h175
  };

endpackage

// File: rtl/key_evt_fifo.sv
// Per-channel event FIFO with registered head and valid; drops pushes when full unless a pop frees a slot.
module key_evt_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_q, rd_q, wr_n, rd_n;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, pop, push_ok;

  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = valid & pop_ready;
  assign push_ok = push & (~full | pop);
  assign drop_c  = push & full & ~pop;
  assign wr_n    = wr_q + PW'(push_ok);
  assign rd_n    = rd_q + PW'(pop);

  // Head is precomputed so evt_data comes straight from a flop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      valid <= 1'b0;
      dout  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) mem_q[wr_q[AW-1:0]] <= din;
      wr_q  <= wr_n;
      rd_q  <= rd_n;
      valid <= (wr_n != rd_n);
      dout  <= (push_ok && (wr_q[AW-1:0] == rd_n[AW-1:0])) ? din : mem_q[rd_n[AW-1:0]];
    end
  end

endmodule

// File: rtl/ps2_key_router.sv
// Decodes PS2 make/break sequences and routes mapped keys to per-channel held bitmaps and event FIFOs.
module ps2_key_router
  import ps2_key_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned KEYS_PER_CH = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [NUM_CH*KEYS_PER_CH*KEY_ENTRY_W-1:0] KEY_MAP = DEFAULT_KEY_MAP
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        scan_valid,
  input  logic [7:0]                                  scan_code,
  output logic [NUM_CH-1:0]                           evt_valid,
  input  logic [NUM_CH-1:0]                           evt_ready,
  output logic [NUM_CH*($clog2(KEYS_PER_CH)+1)-1:0]   evt_data,
  output logic [NUM_CH*KEYS_PER_CH-1:0]               key_held,
  output logic [NUM_CH-1:0]                           overflow,
  input  logic [NUM_CH-1:0]                           clear_overflow
);

  localparam int unsigned IDX_W = $clog2(KEYS_PER_CH);
  localparam int unsigned EVT_W = IDX_W + 1;

  dec_state_e state_q, state_n;
  logic       lk_en, lk_make;
  key_entry_t lk_key;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= DEC_IDLE;
    else       state_q <= state_n;
  end

  // Prefix tracking; a lookup is requested only on a terminating byte
  always_comb begin
    state_n = state_q;
    lk_en   = 1'b0;
    lk_make = 1'b0;
    lk_key  = '0;
    if (scan_valid) begin
      case (state_q)
        DEC_IDLE: begin
          if (scan_code == PS2_EXT)      state_n = DEC_EXT;
          else if (scan_code == PS2_BRK) state_n = DEC_BRK;
          else if (scan_code != PS2_PAUSE) begin
            lk_en   = 1'b1;
            lk_make = 1'b1;
            lk_key  = '{ext: 1'b0, code: scan_code};
          end
        end
        DEC_EXT: begin
          if (scan_code == PS2_BRK) state_n = DEC_EXT_BRK;
          else if (scan_code != PS2_EXT) begin
            lk_en   = 1'b1;
            lk_make = 1'b1;
            lk_key  = '{ext: 1'b1, code: scan_code};
            state_n = DEC_IDLE;
          end
        end
        DEC_BRK: begin
          lk_en   = 1'b1;
          lk_key  = '{ext: 1'b0, code: scan_code};
          state_n = DEC_IDLE;
        end
        DEC_EXT_BRK: begin
          lk_en   = 1'b1;
          lk_key  = '{ext: 1'b1, code: scan_code};
          state_n = DEC_IDLE;
        end
        default: state_n = DEC_IDLE;
      endcase
    end
  end

  logic [NUM_CH-1:0] ch_hit, ch_sel;
  logic [IDX_W-1:0]  ch_idx [NUM_CH];
  logic              lower_hit;

  // Descending scan so the lowest matching index is left standing
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_hit[c] = 1'b0;
      ch_idx[c] = '0;
      for (int k = KEYS_PER_CH - 1; k >= 0; k--) begin
        if (KEY_MAP[(c*KEYS_PER_CH + k)*KEY_ENTRY_W +: KEY_ENTRY_W] == lk_key) begin
          ch_hit[c] = 1'b1;
          ch_idx[c] = IDX_W'(k);
        end
      end
    end
  end

  always_comb begin
    lower_hit = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_sel[c] = ch_hit[c] & ~lower_hit;
      lower_hit = lower_hit | ch_hit[c];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [KEYS_PER_CH-1:0] held_q;
    logic                   push, drop_c, ovf_q;

    // Only a state change of the held bit produces an event
    assign push = lk_en & ch_sel[g] & (lk_make ^ held_q[ch_idx[g]]);

    always_ff @(posedge clock or posedge reset) begin
      if (reset)     held_q <= '0;
      else if (push) held_q[ch_idx[g]] <= lk_make;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) ovf_q <= 1'b0;
      else       ovf_q <= (ovf_q & ~clear_overflow[g]) | drop_c;
    end

    key_evt_fifo #(
      .WIDTH(EVT_W),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .din       ({lk_make, ch_idx[g]}),
      .pop_ready (evt_ready[g]),
      .valid     (evt_valid[g]),
      .dout      (evt_data[g*EVT_W +: EVT_W]),
      .drop_c    (drop_c)
    );

    assign key_held[g*KEYS_PER_CH +: KEYS_PER_CH] = held_q;
    assign overflow[g] = ovf_q;
  end

endmodule

// File: tb/tb_ps2_key_router.sv
// Bench for ps2_key_router: directed scenarios with literal expectations plus randomized traffic against a queue model.
module tb_ps2_key_router;

  localparam int NUM_CH = 2;
  localparam int KPC    = 8;
  localparam int DEPTH  = 4;
  localparam int EW     = 4;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  scan_valid = 1'b0;
  logic [7:0]            scan_code = 8'h00;
  logic [NUM_CH-1:0]     evt_valid;
  logic [NUM_CH-1:0]     evt_ready = '0;
  logic [NUM_CH*EW-1:0]  evt_data;
  logic [NUM_CH*KPC-1:0] key_held;
  logic [NUM_CH-1:0]     overflow;
  logic [NUM_CH-1:0]     clear_overflow = '0;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_key_router dut (
    .clock          (clock),
    .reset          (reset),
    .scan_valid     (scan_valid),
    .scan_code      (scan_code),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_data       (evt_data),
    .key_held       (key_held),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clock = ~clock;

  // Reference key table {ext, code}: index = channel*8 + key
  logic [8:0] tbl [16] = '{9'h175, 9'h16B, 9'h172, 9'h174, 9'h016, 9'h01E, 9'h026, 9'h04D,
                           9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h02C, 9'h02D, 9'h025, 9'h02E};

  bit         m_held [NUM_CH][KPC];
  logic [3:0] m_q    [NUM_CH][DEPTH];
  int         m_cnt  [NUM_CH];
  bit         m_ovf  [NUM_CH];
  bit         m_drop [NUM_CH];
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_lookup(input bit mk, input bit ex, input logic [7:0] code);
    int hit;
    int c;
    int k;
    hit = -1;
    for (int i = 0; i < 16; i++)
      if (hit < 0 && tbl[i] == {ex, code}) hit = i;
    if (hit >= 0) begin
      c = hit / KPC;
      k = hit % KPC;
      if (m_held[c][k] != mk) begin
        m_held[c][k] = mk;
        if (m_cnt[c] < DEPTH) begin
          m_q[c][m_cnt[c]] = {mk, 3'(k)};
          m_cnt[c]++;
        end else begin
          m_drop[c] = 1'b1;
        end
      end
    end
  endtask

  // Reference model: prefix flags, held table, bounded event lists
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_cnt[c] = 0;
        m_ovf[c] = 1'b0;
        for (int k = 0; k < KPC; k++) m_held[c][k] = 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_drop[c] = 1'b0;
        if (evt_ready[c] && m_cnt[c] > 0) begin
          for (int i = 0; i < DEPTH - 1; i++) m_q[c][i] = m_q[c][i+1];
          m_cnt[c]--;
        end
      end
      if (scan_valid) begin
        if (m_brk) begin
          m_lookup(1'b0, m_ext, scan_code);
          m_brk = 1'b0;
          m_ext = 1'b0;
        end else if (scan_code == 8'hF0) begin
          m_brk = 1'b1;
        end else if (scan_code == 8'hE0) begin
          m_ext = 1'b1;
        end else if (!(scan_code == 8'hE1 && !m_ext)) begin
          m_lookup(1'b1, m_ext, scan_code);
          m_ext = 1'b0;
        end
      end
      for (int c = 0; c < NUM_CH; c++)
        m_ovf[c] = (m_ovf[c] && !clear_overflow[c]) || m_drop[c];
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    logic [NUM_CH*KPC-1:0] exp_held;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < KPC; k++) exp_held[c*KPC + k] = m_held[c][k];
      chk($sformatf("evt_valid[%0d]", c), 32'(evt_valid[c]), 32'(m_cnt[c] != 0));
      chk($sformatf("overflow[%0d]", c), 32'(overflow[c]), 32'(m_ovf[c]));
      if (m_cnt[c] != 0)
        chk($sformatf("evt_data[%0d]", c), 32'(evt_data[c*EW +: EW]), 32'(m_q[c][0]));
    end
    chk("key_held", 32'(key_held), 32'(exp_held));
  end

  task automatic cyc(input bit v, input logic [7:0] code);
    scan_valid = v;
    scan_code  = code;
    @(posedge clock);
    #1;
    scan_valid = 1'b0;
  endtask

  task automatic drain();
    evt_ready = '1;
    repeat (DEPTH + 1) cyc(1'b0, 8'h00);
    evt_ready = '0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_evt_valid", 32'(evt_valid), 32'h0);
    chk("rst_evt_data", 32'(evt_data), 32'h0);
    chk("rst_key_held", 32'(key_held), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);

    // Plain make on channel 1, then pop
    cyc(1'b1, 8'h1D);
    chk("w_make_valid", 32'(evt_valid), 32'h2);
    chk("w_make_data", 32'(evt_data[7:4]), 32'h8);
    chk("w_held", 32'(key_held[8]), 32'h1);
    evt_ready = 2'b10;
    cyc(1'b0, 8'h00);
    evt_ready = '0;
    chk("w_pop_empty", 32'(evt_valid), 32'h0);
    cyc(1'b1, 8'hF0);
    cyc(1'b1, 8'h1D);
    drain();

    // Extended make and break
    cyc(1'b1, 8'hE0);
    cyc(1'b1, 8'h75);
    chk("up_make_data", 32'(evt_data[3:0]), 32'h8);
    chk("up_held", 32'(key_held[0]), 32'h1);
    drain();
    cyc(1'b1, 8'hE0);
    cyc(1'b1, 8'hF0);
    cyc(1'b1, 8'h75);
    chk("up_brk_valid", 32'(evt_valid[0]), 32'h1);
    chk("up_brk_data", 32'(evt_data[3:0]), 32'h0);
    chk("up_released", 32'(key_held[0]), 32'h0);
    drain();

    // Typematic repeat yields one make and one break
    repeat (5) cyc(1'b1, 8'h1D);
    cyc(1'b1, 8'hF0);
    cyc(1'b1, 8'h1D);
    chk("typ_head_make", 32'(evt_data[7:4]), 32'h8);
    evt_ready = 2'b10;
    cyc(1'b0, 8'h00);
    evt_ready = '0;
    chk("typ_second_valid", 32'(evt_valid[1]), 32'h1);
    chk("typ_second_brk", 32'(evt_data[7:4]), 32'h0);
    evt_ready = 2'b10;
    cyc(1'b0, 8'h00);
    evt_ready = '0;
    chk("typ_only_two", 32'(evt_valid[1]), 32'h0);

    // Overflow on channel 0
    cyc(1'b1, 8'h16);
    cyc(1'b1, 8'h1E);
    cyc(1'b1, 8'h26);
    cyc(1'b1, 8'h4D);
    chk("ovf_not_yet", 32'(overflow[0]), 32'h0);
    cyc(1'b1, 8'hF0);
    cyc(1'b1, 8'h16);
    chk("ovf_set", 32'(overflow[0]), 32'h1);
    chk("ovf_held_updated", 32'(key_held[4]), 32'h0);
    chk("ovf_head_kept", 32'(evt_data[3:0]), 32'hC);
    clear_overflow = 2'b01;
    cyc(1'b0, 8'h00);
    clear_overflow = '0;
    chk("ovf_cleared", 32'(overflow[0]), 32'h0);
    cyc(1'b1, 8'hF0);
    evt_ready = 2'b01;
    cyc(1'b1, 8'h1E);
    evt_ready = '0;
    chk("full_pushpop_no_ovf", 32'(overflow[0]), 32'h0);
    chk("full_pushpop_head", 32'(evt_data[3:0]), 32'hD);
    drain();

    // Reset after an E0 prefix
    cyc(1'b1, 8'hE0);
    #2 reset = 1'b1;
    #4 reset = 1'b0;
    @(posedge clock);
    #1;
    cyc(1'b1, 8'h75);
    chk("rst_mid_no_evt", 32'(evt_valid), 32'h0);
    chk("rst_mid_no_held", 32'(key_held), 32'h0);
    cyc(1'b1, 8'hF0);
    cyc(1'b1, 8'h16);
    chk("brk_unheld_no_evt", 32'(evt_valid), 32'h0);

    // Unmapped byte and pause prefix are ignored
    cyc(1'b1, 8'h2A);
    cyc(1'b1, 8'hE1);
    chk("e1_no_evt", 32'(evt_valid), 32'h0);
    cyc(1'b1, 8'h16);
    chk("after_e1_valid", 32'(evt_valid[0]), 32'h1);
    chk("after_e1_data", 32'(evt_data[3:0]), 32'hC);
    drain();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [7:0] code;
      r = int'($urandom_range(0, 9));
      if (r < 6)       code = tbl[$urandom_range(0, 15)][7:0];
      else if (r == 6) code = 8'hE0;
      else if (r == 7) code = 8'hF0;
      else if (r == 8) code = 8'hE1;
      else             code = 8'($urandom);
      evt_ready      = 2'($urandom);
      clear_overflow = ($urandom_range(0, 19) == 0) ? 2'($urandom) : 2'b00;
      cyc($urandom_range(0, 9) < 6, code);
    end
    clear_overflow = '0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
